// File: rtl/ones_mod4_frame_tx_if.sv
// Handshake and serial-output bundle for ones_mod4_frame_tx.
// chk_ok exists only when ONES_MOD4_SELFCHK_EN is defined.
interface ones_mod4_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out;
  logic             out_valid;
  logic             sof;
  logic             eof;
`ifdef ONES_MOD4_SELFCHK_EN
  logic             chk_ok;
`endif

  // master = word source / frame sink, slave = the transmitter
  modport master (
    output in_data, in_valid,
    input  in_ready, out, out_valid, sof, eof
`ifdef ONES_MOD4_SELFCHK_EN
    , input chk_ok
`endif
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out, out_valid, sof, eof
`ifdef ONES_MOD4_SELFCHK_EN
    , output chk_ok
`endif
  );
endinterface

// File: rtl/ones_mod4_frame_tx.sv
// Serial frame transmitter: WIDTH data bits MSB-first plus a 3-bit pad making the frame's 1-count 0 mod 4.
// Optional self-check counter and chk_ok output enabled by defining ONES_MOD4_SELFCHK_EN.
module ones_mod4_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ones_mod4_frame_tx_if.slave   bus
);

  localparam int IDX_W = $clog2(WIDTH + 4);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       pad_q, pad_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             in_ready;
  logic             accept;
  logic [1:0]       k;

  // idx counts whichever bit is currently on the output, data or pad
  assign in_ready = (state_q == IDLE) || ((state_q == PAD) && (idx_q == IDX_W'(2)));
  assign accept   = bus.in_valid && in_ready;
  assign k        = 2'd0 - cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pad_d       = pad_q;
    shift_d     = shift_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;

    case (state_q)
      DATA: begin
        out_valid_d = 1'b1;
        if (idx_q == LAST_DATA) begin
          // cnt already includes the last data bit, so k is final here
          state_d = PAD;
          idx_d   = '0;
          out_d   = (k == 2'd3);
          pad_d   = {k >= 2'd2, k >= 2'd1};
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          out_d   = shift_q[WIDTH-1];
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 2'(shift_q[WIDTH-1]);
        end
      end
      PAD: begin
        if (idx_q == IDX_W'(0)) begin
          out_valid_d = 1'b1;
          out_d       = pad_q[1];
          idx_d       = IDX_W'(1);
        end else if (idx_q == IDX_W'(1)) begin
          out_valid_d = 1'b1;
          out_d       = pad_q[0];
          eof_d       = 1'b1;
          idx_d       = IDX_W'(2);
        end else begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // cnt restarts from the first bit, which is counted as it is loaded
    if (accept) begin
      state_d     = DATA;
      idx_d       = '0;
      out_d       = bus.in_data[WIDTH-1];
      out_valid_d = 1'b1;
      sof_d       = 1'b1;
      shift_d     = bus.in_data << 1;
      cnt_d       = 2'(bus.in_data[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pad_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pad_q       <= pad_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sof       = sof_q;
  assign bus.eof       = eof_q;

`ifdef ONES_MOD4_SELFCHK_EN
  // Independent count of the bits actually driven, so a fault in cnt/pad shows up
  logic [1:0] chk_cnt_q;
  logic [1:0] chk_sum;
  logic       chk_ok_q;

  assign chk_sum = (sof_q ? 2'd0 : chk_cnt_q) + 2'(out_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_cnt_q <= '0;
      chk_ok_q  <= 1'b0;
    end else begin
      if (out_valid_q) begin
        chk_cnt_q <= chk_sum;
      end
      chk_ok_q <= eof_q && (chk_sum == 2'd0);
    end
  end

  assign bus.chk_ok = chk_ok_q;
`endif

endmodule

// File: doc/ones_mod4_frame_tx.md
# ones_mod4_frame_tx

Serial frame transmitter that produces bit streams with a total count of 1s that is always a multiple of 4. It takes parallel words over a valid/ready handshake and shifts each word out MSB-first on a single serial line. After the data it appends a 3-bit pad trailer that brings the frame's total 1-count to 0 mod 4. It is the transmit end of the multiple-of-4-ones serial checker: a checker reset at frame start asserts its output on the last pad bit of every frame.

## Interface
- `WIDTH`, 8, data bits per frame (≥1); frame length is WIDTH+3 bits
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset. One clock; reset is asynchronous and active-low.
- `in_data`  input  WIDTH  parallel word to send
- `in_valid`  input  1  `in_data` is valid
- `in_ready`  output  1  block can accept a word this cycle
- `out`  output  1  serial bit
- `out_valid`  output  1  `out` carries a frame bit this cycle
- `sof`  output  1  high with the first data bit of a frame
- `eof`  output  1  high with the last pad bit of a frame
- `chk_ok`  output  1  only with `ONES_MOD4_SELFCHK_EN`; see Configuration

## Operation
- States: IDLE, DATA, PAD.
- `in_ready` is 1 in IDLE and in PAD on the third pad bit; it is 0 otherwise.
- Accept: `in_valid & in_ready` at a rising edge.
  - Captures `in_data` into the shift register.
  - Clears the 2-bit ones counter `cnt` and the bit index.
  - Enters DATA.
- DATA, WIDTH cycles:
  - `out` = shift-register MSB, `out_valid` = 1.
  - The register shifts left each cycle.
  - `cnt` increments (mod 4, wraps 3→0) for each 1 sent.
  - `sof` = 1 on the first DATA cycle only.
  - After the last data bit, the state goes to PAD.
- PAD, 3 cycles. With k = (4 − cnt) mod 4, the pad bits in order are:
  - bit 0 = (k==3)
  - bit 1 = (k≥2)
  - bit 2 = (k≥1)
  - This gives the patterns k=0→000, 1→001, 2→011, 3→111.
  - k is fixed when PAD is entered. The pad bits are not counted back into `cnt`.
  - `eof` = 1 on pad bit 2.
- After pad bit 2:
  - If a word was accepted that cycle, go to DATA. This is back-to-back with no idle gap, and `sof` on the next cycle.
  - Otherwise go to IDLE.
- In IDLE: `out` = 0, `out_valid` = 0, `sof` = 0, `eof` = 0.
- `in_data` is ignored while `in_ready` = 0. Upstream must hold `in_valid` and `in_data` until accepted.
- Reset asserted mid-frame aborts the frame immediately with no pad. Upstream sees a truncated frame.

## Timing
- Reset values:
  - State = IDLE, `cnt` = 0.
  - `out` = 0, `out_valid` = 0, `sof` = 0, `eof` = 0, `chk_ok` = 0.
  - `in_ready` = 1.
- All outputs except `in_ready` are registered. `in_ready` decodes only from state and bit index; it has no combinational path from `in_valid`.
- Latency: first data bit appears on the cycle after the accept edge.
- Frame occupies exactly WIDTH+3 consecutive `out_valid` cycles.
- Sustained throughput: one word per WIDTH+3 cycles.
- Reset release is synchronised by the environment; the block makes no assumption about reset release timing.

## Configuration
- `ONES_MOD4_SELFCHK_EN` defined:
  - Adds an independent 2-bit counter of all 1s driven on `out` during the frame, cleared on `sof`.
  - `chk_ok` is registered and pulses 1 for one cycle, on the cycle after `eof`, if the count including the final bit equals 0 mod 4. It is 0 otherwise.
  - A 0 on that cycle indicates an internal fault.
- Undefined: the port `chk_ok` and its counter are absent; all other behaviour is identical.

## Test plan
- Reset, WIDTH=8, send 8'h80 → `out` sequence 1,0,0,0,0,0,0,0 then pad 1,1,1; `sof` on bit 0, `eof` on last pad; 11 `out_valid` cycles.
- Send 8'hFF, 8'h00, 8'hB0, 8'h03 → pads 000, 000, 001, 011 respectively.
- Every frame: a reference mod-4 ones counter reset at `sof` reads 0 on the `eof` cycle.
- Hold `in_valid` high with a queue of 3 words → `in_ready` pulses on each pad bit 2; frames are contiguous, `out_valid` never drops, and each `sof` immediately follows an `eof`.
- `in_valid` toggled during DATA with different `in_data` → the transmitted frame is unchanged and no extra accept occurs.
- Drive `rst` = 0 at data bit 4 → all outputs 0 and `in_ready` = 1 asynchronously. After release, a new word is sent cleanly with correct pad; with `ONES_MOD4_SELFCHK_EN`, `chk_ok` = 1 one cycle after each `eof`.
